// File: rtl/periph_to_reg_pipe.sv
// Peripheral-bus to register-interface bridge.
// Requests are forwarded to the register interface either combinationally
// (CutReq = 0) or through a one-entry request slot (CutReq = 1). Register
// responses are collected in a Depth-entry FIFO and returned on the r_* channel
// with valid/ready handshaking. Grants are throttled by a credit scheme so the
// FIFO can never overflow: every granted transaction owns a FIFO entry.
module periph_to_reg_pipe #(
    parameter int unsigned AW     = 32,
    parameter int unsigned DW     = 32,
    parameter int unsigned BW     = 8,
    parameter int unsigned IW     = 1,
    parameter int unsigned Depth  = 2,
    parameter logic        CutReq = 1'b1,
    parameter type req_t = struct packed {
        logic [AW-1:0]    addr;
        logic             write;
        logic [DW-1:0]    wdata;
        logic [DW/BW-1:0] wstrb;
        logic             valid;
    },
    parameter type rsp_t = struct packed {
        logic [DW-1:0] rdata;
        logic          error;
        logic          ready;
    }
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_i,
    input  logic [AW-1:0]    add_i,
    input  logic             wen_i,
    input  logic [DW-1:0]    wdata_i,
    input  logic [DW/BW-1:0] be_i,
    input  logic [IW-1:0]    id_i,
    output logic             gnt_o,
    output logic [DW-1:0]    r_rdata_o,
    output logic             r_opc_o,
    output logic [IW-1:0]    r_id_o,
    output logic             r_valid_o,
    input  logic             r_ready_i,
    output req_t             reg_req_o,
    input  rsp_t             reg_rsp_i
);

    localparam int unsigned SW = DW / BW;
    localparam int unsigned PW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CW = $clog2(Depth + 1);

    localparam logic [PW-1:0] LastIdx  = PW'(Depth - 1);
    localparam logic [CW:0]   DepthLim = (CW + 1)'(Depth);

    // Response FIFO storage and bookkeeping
    logic [DW-1:0] fifo_rdata_q [Depth];
    logic          fifo_err_q   [Depth];
    logic [IW-1:0] fifo_id_q    [Depth];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Push side, driven by whichever request path is built
    logic          push;
    logic [DW-1:0] push_rdata;
    logic          push_err;
    logic [IW-1:0] push_id;

    logic          pop;
    logic          slot_valid;
    logic [CW:0]   inflight;
    logic          credit;

    assign r_valid_o = (cnt_q != '0);
    assign r_rdata_o = fifo_rdata_q[rd_ptr_q];
    assign r_opc_o   = fifo_err_q[rd_ptr_q];
    assign r_id_o    = fifo_id_q[rd_ptr_q];

    // Credit: a new grant is allowed only if its response is guaranteed a FIFO entry
    always_comb begin
        pop      = r_valid_o & r_ready_i;
        inflight = {1'b0, cnt_q} + {{CW{1'b0}}, slot_valid};
        credit   = (inflight - {{CW{1'b0}}, pop}) < DepthLim;
    end

    // Pointer wrap and occupancy next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == LastIdx) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LastIdx) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // FIFO pointer/occupancy registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // FIFO storage; cleared on reset so the r_* outputs read zero afterwards
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                fifo_rdata_q[i] <= '0;
                fifo_err_q[i]   <= 1'b0;
                fifo_id_q[i]    <= '0;
            end
        end else if (push) begin
            fifo_rdata_q[wr_ptr_q] <= push_rdata;
            fifo_err_q[wr_ptr_q]   <= push_err;
            fifo_id_q[wr_ptr_q]    <= push_id;
        end
    end

    if (CutReq) begin : gen_cut
        logic          slot_valid_q, slot_valid_d;
        logic [AW-1:0] slot_addr_q;
        logic          slot_write_q;
        logic [DW-1:0] slot_wdata_q;
        logic [SW-1:0] slot_wstrb_q;
        logic [IW-1:0] slot_id_q;
        logic          slot_fire;

        // Slot handshake: the slot may be refilled in the same cycle it fires
        always_comb begin
            slot_fire    = slot_valid_q & reg_rsp_i.ready;
            gnt_o        = req_i & credit & (~slot_valid_q | slot_fire);
            slot_valid_d = gnt_o | (slot_valid_q & ~slot_fire);
            slot_valid   = slot_valid_q;
            push         = slot_fire;
            push_rdata   = reg_rsp_i.rdata;
            push_err     = reg_rsp_i.error;
            push_id      = slot_id_q;
        end

        // Register request is presented straight from the slot
        always_comb begin
            reg_req_o       = '0;
            reg_req_o.addr  = slot_addr_q;
            reg_req_o.write = slot_write_q;
            reg_req_o.wdata = slot_wdata_q;
            reg_req_o.wstrb = slot_wstrb_q;
            reg_req_o.valid = slot_valid_q;
        end

        // Slot registers: loaded only on a grant, so they hold while the target stalls
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                slot_valid_q <= 1'b0;
                slot_addr_q  <= '0;
                slot_write_q <= 1'b0;
                slot_wdata_q <= '0;
                slot_wstrb_q <= '0;
                slot_id_q    <= '0;
            end else begin
                slot_valid_q <= slot_valid_d;
                if (gnt_o) begin
                    slot_addr_q  <= add_i;
                    slot_write_q <= ~wen_i;
                    slot_wdata_q <= wdata_i;
                    slot_wstrb_q <= be_i;
                    slot_id_q    <= id_i;
                end
            end
        end
    end else begin : gen_pass
        // Pass-through request; the response is captured in the grant cycle
        always_comb begin
            slot_valid = 1'b0;
            gnt_o      = req_i & credit & reg_rsp_i.ready;
            push       = gnt_o;
            push_rdata = reg_rsp_i.rdata;
            push_err   = reg_rsp_i.error;
            push_id    = id_i;
        end

        // Register request driven directly from the peripheral inputs
        always_comb begin
            reg_req_o       = '0;
            reg_req_o.addr  = add_i;
            reg_req_o.write = ~wen_i;
            reg_req_o.wdata = wdata_i;
            reg_req_o.wstrb = be_i;
            reg_req_o.valid = req_i & credit;
        end
    end

endmodule

// File: tb/tb_periph_to_reg_pipe.sv
// Bench for periph_to_reg_pipe: one pass-through instance (CutReq=0, Depth=1)
// and one registered instance (CutReq=1, Depth=2). Expected responses are queued
// when a grant is issued; a monitor pops and compares on every r_valid & r_ready.
module tb_periph_to_reg_pipe;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } rsp_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic [1:0]  id;
        int          due;
    } exp_t;

    localparam logic [31:0] RspKey = 32'hA5A5_0000;

    logic clk;
    logic rst_n;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    exp_t sb0[$];
    exp_t sb1[$];

    // DUT0 signals
    logic        d0_req, d0_wen, d0_gnt, d0_r_opc, d0_r_valid, d0_r_ready;
    logic [31:0] d0_add, d0_wdata, d0_r_rdata;
    logic [3:0]  d0_be;
    logic [1:0]  d0_id, d0_r_id;
    req_t        d0_reg;
    rsp_t        d0_rsp;

    // DUT1 signals
    logic        d1_req, d1_wen, d1_gnt, d1_r_opc, d1_r_valid, d1_r_ready;
    logic [31:0] d1_add, d1_wdata, d1_r_rdata;
    logic [3:0]  d1_be;
    logic [1:0]  d1_id, d1_r_id;
    req_t        d1_reg;
    rsp_t        d1_rsp;
    logic        d1_ready, d1_err;

    periph_to_reg_pipe #(
        .AW(32), .DW(32), .BW(8), .IW(2), .Depth(1), .CutReq(1'b0),
        .req_t(req_t), .rsp_t(rsp_t)
    ) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n),
        .req_i(d0_req), .add_i(d0_add), .wen_i(d0_wen), .wdata_i(d0_wdata),
        .be_i(d0_be), .id_i(d0_id), .gnt_o(d0_gnt),
        .r_rdata_o(d0_r_rdata), .r_opc_o(d0_r_opc), .r_id_o(d0_r_id),
        .r_valid_o(d0_r_valid), .r_ready_i(d0_r_ready),
        .reg_req_o(d0_reg), .reg_rsp_i(d0_rsp)
    );

    periph_to_reg_pipe #(
        .AW(32), .DW(32), .BW(8), .IW(2), .Depth(2), .CutReq(1'b1),
        .req_t(req_t), .rsp_t(rsp_t)
    ) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n),
        .req_i(d1_req), .add_i(d1_add), .wen_i(d1_wen), .wdata_i(d1_wdata),
        .be_i(d1_be), .id_i(d1_id), .gnt_o(d1_gnt),
        .r_rdata_o(d1_r_rdata), .r_opc_o(d1_r_opc), .r_id_o(d1_r_id),
        .r_valid_o(d1_r_valid), .r_ready_i(d1_r_ready),
        .reg_req_o(d1_reg), .reg_rsp_i(d1_rsp)
    );

    // Register target model for DUT1: read data is a fixed function of the address
    always_comb begin
        d1_rsp       = '0;
        d1_rsp.rdata = d1_reg.addr ^ RspKey;
        d1_rsp.error = d1_err;
        d1_rsp.ready = d1_ready;
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic exp0(input logic [31:0] rd, input logic er, input logic [1:0] id, input int due);
        exp_t e;
        e.rdata = rd; e.err = er; e.id = id; e.due = due;
        sb0.push_back(e);
    endtask

    task automatic exp1(input logic [31:0] rd, input logic er, input logic [1:0] id, input int due);
        exp_t e;
        e.rdata = rd; e.err = er; e.id = id; e.due = due;
        sb1.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Response monitor for DUT0
    always @(negedge clk) begin
        if (rst_n && d0_r_valid && d0_r_ready) begin
            if (sb0.size() == 0) begin
                tests++; fails++;
                $display("FAIL d0_unexpected_rsp: got id %0d, expected no response", d0_r_id);
            end else begin
                exp_t e;
                e = sb0.pop_front();
                chk("d0_rdata", d0_r_rdata, e.rdata);
                chk("d0_opc", 32'(d0_r_opc), 32'(e.err));
                chk("d0_id", 32'(d0_r_id), 32'(e.id));
                if (e.due >= 0) chk("d0_latency", 32'(cyc), 32'(e.due));
            end
        end
    end

    // Response monitor for DUT1
    always @(negedge clk) begin
        if (rst_n && d1_r_valid && d1_r_ready) begin
            if (sb1.size() == 0) begin
                tests++; fails++;
                $display("FAIL d1_unexpected_rsp: got id %0d, expected no response", d1_r_id);
            end else begin
                exp_t e;
                e = sb1.pop_front();
                chk("d1_rdata", d1_r_rdata, e.rdata);
                chk("d1_opc", 32'(d1_r_opc), 32'(e.err));
                chk("d1_id", 32'(d1_r_id), 32'(e.id));
                if (e.due >= 0) chk("d1_latency", 32'(cyc), 32'(e.due));
            end
        end
    end

    // Invariants: no grant without request, no push into a full FIFO without a pop
    always @(negedge clk) begin
        if (d0_gnt && !d0_req) begin
            fails++; $display("FAIL d0_gnt_no_req: got gnt 1, expected 0");
        end
        if (d1_gnt && !d1_req) begin
            fails++; $display("FAIL d1_gnt_no_req: got gnt 1, expected 0");
        end
        if (rst_n && u_dut0.push && (u_dut0.cnt_q == 1'd1) && !u_dut0.pop) begin
            fails++; $display("FAIL d0_push_full: got push into full FIFO, expected none");
        end
        if (rst_n && u_dut1.push && (u_dut1.cnt_q == 2'd2) && !u_dut1.pop) begin
            fails++; $display("FAIL d1_push_full: got push into full FIFO, expected none");
        end
    end

    initial begin
        int n;
        rst_n = 1'b0;
        d0_req = 0; d0_add = '0; d0_wen = 1; d0_wdata = '0; d0_be = '0; d0_id = '0;
        d0_r_ready = 1; d0_rsp = '0;
        d1_req = 0; d1_add = '0; d1_wen = 1; d1_wdata = '0; d1_be = '0; d1_id = '0;
        d1_r_ready = 1; d1_ready = 1; d1_err = 0;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_d0_valid", 32'(d0_r_valid), 0);
        chk("rst_d0_rdata", d0_r_rdata, 0);
        chk("rst_d0_id", 32'(d0_r_id), 0);
        chk("rst_d0_opc", 32'(d0_r_opc), 0);
        chk("rst_d0_gnt", 32'(d0_gnt), 0);
        chk("rst_d1_valid", 32'(d1_r_valid), 0);
        chk("rst_d1_rdata", d1_r_rdata, 0);
        chk("rst_d1_id", 32'(d1_r_id), 0);
        chk("rst_d1_regvalid", 32'(d1_reg.valid), 0);
        chk("rst_d1_gnt", 32'(d1_gnt), 0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_d1_valid", 32'(d1_r_valid), 0);
        chk("post_rst_d1_regvalid", 32'(d1_reg.valid), 0);
        tick();

        // DUT0: single read, same-cycle grant, one-cycle latency
        d0_req = 1; d0_add = 32'h100; d0_wen = 1; d0_id = 2'd3;
        d0_rsp = '0; d0_rsp.rdata = 32'hCAFEF00D; d0_rsp.error = 0; d0_rsp.ready = 1;
        @(negedge clk);
        chk("d0_read_gnt", 32'(d0_gnt), 1);
        chk("d0_read_regvalid", 32'(d0_reg.valid), 1);
        chk("d0_read_addr", d0_reg.addr, 32'h100);
        chk("d0_read_write", 32'(d0_reg.write), 0);
        exp0(32'hCAFEF00D, 1'b0, 2'd3, cyc + 1);
        tick();

        // DUT0: full FIFO with pop in the same cycle still grants; write with error
        d0_add = 32'h204; d0_wen = 0; d0_wdata = 32'h11223344; d0_be = 4'hA; d0_id = 2'd1;
        d0_rsp.rdata = 32'hDEAD0001; d0_rsp.error = 1;
        @(negedge clk);
        chk("d0_full_pop_gnt", 32'(d0_gnt), 1);
        chk("d0_write_flag", 32'(d0_reg.write), 1);
        chk("d0_write_wdata", d0_reg.wdata, 32'h11223344);
        chk("d0_write_wstrb", 32'(d0_reg.wstrb), 32'hA);
        exp0(32'hDEAD0001, 1'b1, 2'd1, -1);
        tick();

        // DUT0: full FIFO, no pop -> no credit
        d0_r_ready = 0;
        d0_add = 32'h8; d0_wen = 1; d0_id = 2'd2;
        d0_rsp.rdata = 32'h0BADBEEF; d0_rsp.error = 0;
        @(negedge clk);
        chk("d0_nocredit_gnt", 32'(d0_gnt), 0);
        chk("d0_nocredit_regvalid", 32'(d0_reg.valid), 0);
        chk("d0_nocredit_rvalid", 32'(d0_r_valid), 1);
        tick();
        d0_r_ready = 1;
        @(negedge clk);
        chk("d0_ready_path_gnt", 32'(d0_gnt), 1);
        exp0(32'h0BADBEEF, 1'b0, 2'd2, cyc + 1);
        tick();
        d0_req = 0;
        @(negedge clk);
        chk("d0_idle_gnt", 32'(d0_gnt), 0);
        tick();
        tick();

        // DUT1: four back-to-back writes
        for (int i = 0; i < 4; i++) begin
            d1_req = 1; d1_add = 32'h1000 + 32'(i * 4); d1_wen = 0;
            d1_wdata = 32'h10 + 32'(i) * 32'h01010101; d1_be = 4'hF; d1_id = 2'(i);
            @(negedge clk);
            chk("b2b_gnt", 32'(d1_gnt), 1);
            if (i == 0) begin
                chk("b2b_regvalid_first", 32'(d1_reg.valid), 0);
            end else begin
                chk("b2b_regvalid", 32'(d1_reg.valid), 1);
                chk("b2b_addr", d1_reg.addr, 32'h1000 + 32'((i - 1) * 4));
            end
            exp1((32'h1000 + 32'(i * 4)) ^ RspKey, 1'b0, 2'(i), cyc + 2);
            tick();
        end
        d1_req = 0;
        @(negedge clk);
        chk("b2b_last_regvalid", 32'(d1_reg.valid), 1);
        chk("b2b_last_addr", d1_reg.addr, 32'h100C);
        chk("b2b_last_wdata", d1_reg.wdata, 32'h10 + 32'h03030303);
        chk("b2b_last_write", 32'(d1_reg.write), 1);
        repeat (4) tick();

        // DUT1: response backpressure limits grants to Depth
        d1_r_ready = 0;
        n = 0;
        for (int k = 0; k < 6; k++) begin
            d1_req = 1; d1_add = 32'h2000 + 32'(n * 4); d1_wen = 1; d1_id = 2'(n);
            @(negedge clk);
            if (d1_gnt) begin
                exp1((32'h2000 + 32'(n * 4)) ^ RspKey, 1'b0, 2'(n), -1);
                n++;
            end
            tick();
        end
        chk("stall_grants", 32'(n), 2);
        d1_r_ready = 1;
        @(negedge clk);
        chk("stall_pop_gnt", 32'(d1_gnt), 1);
        chk("stall_pop_valid", 32'(d1_r_valid), 1);
        exp1(32'h2008 ^ RspKey, 1'b0, 2'd2, -1);
        tick();
        d1_req = 0; d1_r_ready = 0;
        @(negedge clk);
        chk("stall_still_valid", 32'(d1_r_valid), 1);
        chk("stall_idle_gnt", 32'(d1_gnt), 0);
        tick();
        d1_r_ready = 1;
        repeat (5) tick();

        // DUT1: target stalls with the slot loaded; slot must hold, then fire with error
        d1_ready = 0;
        d1_req = 1; d1_add = 32'h3000; d1_wen = 0; d1_wdata = 32'hA5A55A5A; d1_be = 4'b0110; d1_id = 2'd1;
        @(negedge clk);
        chk("hold_first_gnt", 32'(d1_gnt), 1);
        tick();
        d1_add = 32'h3100; d1_wen = 1; d1_wdata = 32'h01234567; d1_be = 4'b1001; d1_id = 2'd2;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("hold_addr", d1_reg.addr, 32'h3000);
            chk("hold_wdata", d1_reg.wdata, 32'hA5A55A5A);
            chk("hold_wstrb", 32'(d1_reg.wstrb), 32'h6);
            chk("hold_write", 32'(d1_reg.write), 1);
            chk("hold_regvalid", 32'(d1_reg.valid), 1);
            chk("hold_gnt", 32'(d1_gnt), 0);
            chk("hold_no_rsp", 32'(d1_r_valid), 0);
            tick();
        end
        d1_ready = 1; d1_err = 1;
        @(negedge clk);
        chk("fire_reload_gnt", 32'(d1_gnt), 1);
        exp1(32'h3000 ^ RspKey, 1'b1, 2'd1, cyc + 1);
        exp1(32'h3100 ^ RspKey, 1'b0, 2'd2, cyc + 2);
        tick();
        d1_req = 0; d1_err = 0;
        repeat (5) tick();

        // DUT1: reset with one response queued and the slot occupied
        d1_r_ready = 0; d1_ready = 1;
        d1_req = 1; d1_add = 32'h5000; d1_wen = 1; d1_id = 2'd0;
        @(negedge clk);
        chk("prerst_gnt0", 32'(d1_gnt), 1);
        tick();
        d1_add = 32'h5004; d1_id = 2'd1;
        @(negedge clk);
        chk("prerst_gnt1", 32'(d1_gnt), 1);
        tick();
        d1_req = 0; d1_ready = 0;
        @(negedge clk);
        chk("prerst_slot_valid", 32'(d1_reg.valid), 1);
        chk("prerst_rvalid", 32'(d1_r_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("inrst_rvalid", 32'(d1_r_valid), 0);
        chk("inrst_rdata", d1_r_rdata, 0);
        chk("inrst_rid", 32'(d1_r_id), 0);
        chk("inrst_opc", 32'(d1_r_opc), 0);
        chk("inrst_regvalid", 32'(d1_reg.valid), 0);
        sb1.delete();
        tick();
        tick();
        rst_n = 1'b1;
        d1_ready = 1; d1_r_ready = 1;
        d1_req = 1; d1_add = 32'h6000; d1_wen = 1; d1_id = 2'd2;
        @(negedge clk);
        chk("postrst_gnt", 32'(d1_gnt), 1);
        exp1(32'h6000 ^ RspKey, 1'b0, 2'd2, cyc + 2);
        tick();
        d1_req = 0;
        repeat (5) tick();

        chk("sb0_drained", 32'(sb0.size()), 0);
        chk("sb1_drained", 32'(sb1.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
